// File: rtl/xbar_gather_pkg.sv
// rtl/xbar_gather_pkg.sv - shared types and helpers for the gather crossbar stream
package xbar_gather_pkg;

  // Occupancy of the two-entry elastic buffer (output register O, skid register S)
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  localparam int ERR_CNT_W = 16;

  // Selector width for n candidates; a single candidate still needs one bit
  // so that the out-of-range value 1 can be expressed.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbar_gather_lane.sv
// rtl/xbar_gather_lane.sv - combinational word select and range flag for one output lane
module xbar_gather_lane
  import xbar_gather_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int WORD_SIZE = 8,
  localparam int SEL_W    = sel_w(NUM_IN)
) (
  input  logic [NUM_IN*WORD_SIZE-1:0] in_data,
  input  logic [SEL_W-1:0]            sel,
  output logic [WORD_SIZE-1:0]        word,
  output logic                        oob
);

  // Match the selector against every legal index; no match means out of range,
  // so the lane is zeroed instead of wrapping onto some other word.
  always_comb begin
    word = '0;
    oob  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        word = in_data[k*WORD_SIZE +: WORD_SIZE];
        oob  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/xbar_gather_stream.sv
// rtl/xbar_gather_stream.sv - flow-controlled lane gather with 2-entry elastic buffer (option: XBAR_GATHER_ERR_CNT_EN)
module xbar_gather_stream
  import xbar_gather_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int NUM_OUT   = 3,
  parameter int WORD_SIZE = 8,
  localparam int SEL_W    = sel_w(NUM_IN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_IN*WORD_SIZE-1:0]   in_data,
  input  logic [NUM_OUT*SEL_W-1:0]      in_sel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_OUT*WORD_SIZE-1:0]  out_data,
  output logic [NUM_OUT-1:0]            out_oob,
  output logic                          err_sticky,
`ifdef XBAR_GATHER_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0]          err_cnt,
`endif
  input  logic                          err_clr
);

  typedef struct packed {
    logic [WORD_SIZE-1:0] word;
    logic                 oob;
  } lane_res_t;

  logic [NUM_OUT-1:0][WORD_SIZE-1:0] lane_word;
  logic [NUM_OUT-1:0]                lane_oob;
  lane_res_t [NUM_OUT-1:0]           sel_res;

  buf_state_e              state_q, state_d;
  lane_res_t [NUM_OUT-1:0] o_q, o_d;
  lane_res_t [NUM_OUT-1:0] s_q, s_d;
  logic                    in_ready_q, in_ready_d;
  logic                    err_sticky_q, err_sticky_d;

  logic accept;
  logic drain;
  logic bad_beat;

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_lane
    xbar_gather_lane #(
      .NUM_IN    (NUM_IN),
      .WORD_SIZE (WORD_SIZE)
    ) u_lane (
      .in_data (in_data),
      .sel     (in_sel[j*SEL_W +: SEL_W]),
      .word    (lane_word[j]),
      .oob     (lane_oob[j])
    );
  end

  // Pack the per-lane results; only these, never the raw inputs, get buffered
  always_comb begin
    sel_res = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      sel_res[j].word = lane_word[j];
      sel_res[j].oob  = lane_oob[j];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;
  assign bad_beat  = accept & (|lane_oob);

  // Elastic buffer next state: O always presents the oldest beat, S catches
  // the one beat that arrives while O is stalled.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          o_d     = sel_res;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          o_d = sel_res;
        end else if (accept) begin
          s_d     = sel_res;
          state_d = ST_TWO;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          o_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_TWO);
  end

  // Sticky error: a new bad beat outranks a simultaneous clear
  always_comb begin
    err_sticky_d = bad_beat | (err_sticky_q & ~err_clr);
  end

  // Buffer, handshake and error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      o_q          <= '0;
      s_q          <= '0;
      in_ready_q   <= 1'b1;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      o_q          <= o_d;
      s_q          <= s_d;
      in_ready_q   <= in_ready_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Unpack the output register onto the flat output buses
  always_comb begin
    out_data = '0;
    out_oob  = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      out_data[j*WORD_SIZE +: WORD_SIZE] = o_q[j].word;
      out_oob[j]                         = o_q[j].oob;
    end
  end

  assign err_sticky = err_sticky_q;

`ifdef XBAR_GATHER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating bad-beat counter; a clear restarts it at the coinciding beat
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = bad_beat ? ERR_CNT_W'(1) : '0;
    end else if (bad_beat && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_xbar_gather_stream.sv
// tb/tb_xbar_gather_stream.sv - randomized scoreboard bench for xbar_gather_stream (NUM_IN 4 and 3 builds)
module tb_xbar_gather_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [5:0]  in_sel;
  logic        out_ready;
  logic        err_clr;

  logic        in_ready4, out_valid4, err4;
  logic [23:0] out_data4;
  logic [2:0]  out_oob4;
  logic        in_ready3, out_valid3, err3;
  logic [23:0] out_data3;
  logic [2:0]  out_oob3;
`ifdef XBAR_GATHER_ERR_CNT_EN
  logic [15:0] err_cnt4, err_cnt3;
  int          cnt_m4, cnt_m3;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [26:0] q4[$];
  logic [26:0] q3[$];
  bit          err_m4, err_m3;
  bit          chk_en = 0;
  bit          last_acc;

  always #5 clk = ~clk;

  xbar_gather_stream #(.NUM_IN(4), .NUM_OUT(3), .WORD_SIZE(8)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready4),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid4),
    .out_ready  (out_ready),
    .out_data   (out_data4),
    .out_oob    (out_oob4),
    .err_sticky (err4),
`ifdef XBAR_GATHER_ERR_CNT_EN
    .err_cnt    (err_cnt4),
`endif
    .err_clr    (err_clr)
  );

  xbar_gather_stream #(.NUM_IN(3), .NUM_OUT(3), .WORD_SIZE(8)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready3),
    .in_data    (in_data[23:0]),
    .in_sel     (in_sel),
    .out_valid  (out_valid3),
    .out_ready  (out_ready),
    .out_data   (out_data3),
    .out_oob    (out_oob3),
    .err_sticky (err3),
`ifdef XBAR_GATHER_ERR_CNT_EN
    .err_cnt    (err_cnt3),
`endif
    .err_clr    (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {oob, lanes} for a beat: lane j takes word sel_j if sel_j < nin, else 0 with flag
  function automatic logic [26:0] gather(input logic [31:0] d, input logic [5:0] s, input int nin);
    logic [23:0] od = '0;
    logic [2:0]  oob = '0;
    int          sv;
    for (int j = 0; j < 3; j++) begin
      sv = int'(s[j*2 +: 2]);
      if (sv < nin) od[j*8 +: 8] = d[sv*8 +: 8];
      else oob[j] = 1'b1;
    end
    return {oob, od};
  endfunction

  // One clock: drive, check both DUTs against the model mid-cycle, then advance the model
  task automatic step(input logic r, input logic v, input logic [31:0] d, input logic [5:0] s,
                      input logic ordy, input logic clr);
    bit          acc4, acc3, dr4, dr3, bad4, bad3;
    logic [26:0] g4, g3;
    rst = r; in_valid = v; in_data = d; in_sel = s; out_ready = ordy; err_clr = clr;
    @(negedge clk);
    if (chk_en) begin
      check("ready4", in_ready4, q4.size() < 2);
      check("valid4", out_valid4, q4.size() != 0);
      if (q4.size() != 0) check("beat4", {out_oob4, out_data4}, q4[0]);
      check("err4", err4, err_m4);
      check("ready3", in_ready3, q3.size() < 2);
      check("valid3", out_valid3, q3.size() != 0);
      if (q3.size() != 0) check("beat3", {out_oob3, out_data3}, q3[0]);
      check("err3", err3, err_m3);
`ifdef XBAR_GATHER_ERR_CNT_EN
      check("cnt4", err_cnt4, cnt_m4);
      check("cnt3", err_cnt3, cnt_m3);
`endif
    end
    g4   = gather(d, s, 4);
    g3   = gather(d, s, 3);
    acc4 = v & (q4.size() < 2);
    acc3 = v & (q3.size() < 2);
    dr4  = ordy & (q4.size() != 0);
    dr3  = ordy & (q3.size() != 0);
    bad4 = acc4 & (|g4[26:24]);
    bad3 = acc3 & (|g3[26:24]);
    last_acc = acc4;
    @(posedge clk);
    if (r) begin
      q4.delete(); q3.delete();
      err_m4 = 0; err_m3 = 0;
`ifdef XBAR_GATHER_ERR_CNT_EN
      cnt_m4 = 0; cnt_m3 = 0;
`endif
      chk_en = 1;
    end else begin
      if (dr4) void'(q4.pop_front());
      if (dr3) void'(q3.pop_front());
      if (acc4) q4.push_back(g4);
      if (acc3) q3.push_back(g3);
      err_m4 = bad4 ? 1'b1 : (clr ? 1'b0 : err_m4);
      err_m3 = bad3 ? 1'b1 : (clr ? 1'b0 : err_m3);
`ifdef XBAR_GATHER_ERR_CNT_EN
      cnt_m4 = clr ? int'(bad4) : ((bad4 && cnt_m4 < 65535) ? cnt_m4 + 1 : cnt_m4);
      cnt_m3 = clr ? int'(bad3) : ((bad3 && cnt_m3 < 65535) ? cnt_m3 + 1 : cnt_m3);
`endif
    end
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [5:0]  s;
    logic        v, ordy, clr, hold;
    int          n;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rst_valid", out_valid4, 0);
    check("rst_ready", in_ready4, 1);
    check("rst_data", out_data4, 0);
    check("rst_oob", out_oob4, 0);
    check("rst_err", err4, 0);

    // Directed first beat: words 11,22,33,44 and selectors {2,0,3}
    step(0, 1, 32'h44332211, 6'b11_00_10, 1, 0);
    check("first_valid", out_valid4, 1);
    check("first_data4", out_data4, 24'h441133);
    check("first_oob4", out_oob4, 3'b000);
    check("first_data3", out_data3, 24'h001133);
    check("first_oob3", out_oob3, 3'b100);
    step(0, 0, 0, 0, 1, 0);

    // Backpressure: three beats against a stalled consumer
    step(0, 1, 32'hA1A2A3A4, 6'b00_01_10, 0, 0);
    step(0, 1, 32'hB1B2B3B4, 6'b01_10_00, 0, 0);
    check("bp_full_ready", in_ready4, 0);
    d = 32'hC1C2C3C4; s = 6'b10_00_01;
    step(0, 1, d, s, 0, 0);
    check("bp_third_held", last_acc, 0);
    n = 0;
    do begin
      step(0, 1, d, s, 1, 0);
      n++;
    end while (!last_acc && n < 6);
    check("bp_third_accepted", last_acc, 1);
    n = 0;
    while (q4.size() != 0 && n < 6) begin
      step(0, 0, 0, 0, 1, 0);
      n++;
    end
    check("bp_drained", q4.size(), 0);

    // Sustained stream, consumer always ready
    for (int i = 0; i < 100; i++) step(0, 1, $urandom, 6'($urandom), 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("stream_drained", out_valid4, 0);

    // Out-of-range lane 1 on the three-input build, then sticky clear behaviour
    step(0, 1, 32'h00302010, 6'b00_11_01, 1, 0);
    check("oob_flags", out_oob3, 3'b010);
    check("oob_data", out_data3, 24'h100020);
    check("oob_sticky", err3, 1);
    step(0, 0, 0, 0, 1, 1);
    check("oob_cleared", err3, 0);
    step(0, 1, 32'h00302010, 6'b00_11_01, 1, 1);
    check("oob_set_wins", err3, 1);

    // Reset while both registers are full
    step(0, 1, 32'h11111111, 6'b11_11_11, 0, 0);
    step(0, 1, 32'h22222222, 6'b10_10_10, 0, 0);
    check("mid_full", in_ready4, 0);
    step(1, 1, 32'h33333333, 0, 0, 0);
    check("mid_valid", out_valid3, 0);
    check("mid_ready", in_ready3, 1);
    check("mid_data", out_data3, 0);
    check("mid_err", err3, 0);

    // Random traffic with legal producer holds
    hold = 0; v = 0; d = 0; s = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        v = ($urandom % 4) != 0;
        d = $urandom;
        s = 6'($urandom);
      end
      ordy = ($urandom % 3) != 0;
      clr  = ($urandom % 8) == 0;
      step(0, v, d, s, ordy, clr);
      hold = v & !last_acc;
    end

`ifdef XBAR_GATHER_ERR_CNT_EN
    // Error counter: five bad beats, then a clear coinciding with a sixth
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, $urandom, 6'b00_11_00, 1, 0);
    check("cnt_five", err_cnt3, 5);
    step(0, 1, $urandom, 6'b00_11_00, 1, 1);
    check("cnt_clr_bad", err_cnt3, 1);
    for (int i = 0; i < 65540; i++) step(0, 1, $urandom, 6'b11_00_00, 1, 0);
    check("cnt_saturated", err_cnt3, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
